line_write_buffer: RTL and testbench

- Line-granular write-back buffer between the set-associative cache's memory port and main_mem.
- The upstream port has the same shape and gnt contract as main_mem, so the cache plugs in unchanged.
- Evicted dirty lines are absorbed in a small FIFO and drained to main_mem when it is otherwise idle. Upstream read misses no longer wait behind write-backs.
- Upstream reads that match a buffered line are served from the buffer, so memory never returns stale data.

---
 rtl/cache_pkg.sv | 22 ++
 rtl/line_write_buffer_if.sv | 28 ++
 rtl/line_write_buffer_entries.sv | 70 +++++++
 rtl/line_write_buffer.sv | 165 ++++++++++++++++
 tb/tb_line_write_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Types and default geometry shared by the cache, main_mem and the line write-back buffer.
package cache_pkg;

  localparam int DEF_LINE_ADDR_LEN = 3;
  localparam int DEF_ADDR_LEN      = 9;

  function automatic int line_size(input int line_addr_len);
    return 1 << line_addr_len;
  endfunction

  localparam int LINE_SIZE = line_size(DEF_LINE_ADDR_LEN);

  typedef logic [LINE_SIZE-1:0][31:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    RESP
  } wb_state_e;

endpackage

// File: rtl/line_write_buffer_if.sv
// Line-granular memory port; the cache side and main_mem side share this shape and gnt contract.
interface line_write_buffer_if
  import cache_pkg::*;
#(
  parameter int ADDR_LEN      = DEF_ADDR_LEN,
  parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN
);

  localparam int LSZ = line_size(LINE_ADDR_LEN);

  logic [ADDR_LEN-1:0]    addr;
  logic                   rd_req;
  logic                   wr_req;
  logic [LSZ-1:0][31:0]   wr_line;
  logic [LSZ-1:0][31:0]   rd_line;
  logic                   gnt;

  modport master (
    output addr, rd_req, wr_req, wr_line,
    input  rd_line, gnt
  );

  modport slave (
    input  addr, rd_req, wr_req, wr_line,
    output rd_line, gnt
  );

endinterface

// File: rtl/line_write_buffer_entries.sv
// Storage for buffered lines: valid/addr/line per slot, associative lookup plus head read port.
module wb_entry_array
  import cache_pkg::*;
#(
  parameter int ADDR_LEN  = DEF_ADDR_LEN,
  parameter int LSZ       = LINE_SIZE,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_LEN-1:0]        i_lookup_addr,
  output logic                       o_hit,
  output logic [$clog2(DEPTH)-1:0]   o_hit_idx,
  output logic [LSZ-1:0][31:0]       o_hit_line,
  input  logic [$clog2(DEPTH)-1:0]   i_head_idx,
  output logic [ADDR_LEN-1:0]        o_head_addr,
  output logic [LSZ-1:0][31:0]       o_head_line,
  input  logic                       i_wr_en,
  input  logic [$clog2(DEPTH)-1:0]   i_wr_idx,
  input  logic [ADDR_LEN-1:0]        i_wr_addr,
  input  logic [LSZ-1:0][31:0]       i_wr_line,
  input  logic                       i_inv_en,
  input  logic [$clog2(DEPTH)-1:0]   i_inv_idx
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]     r_valid;
  logic [ADDR_LEN-1:0]  r_addr [DEPTH];
  logic [LSZ-1:0][31:0] r_line [DEPTH];

  logic                 w_hit;
  logic [IDX_W-1:0]     w_hit_idx;

  // At most one valid slot can match, so no priority is needed between hits.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == i_lookup_addr)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  assign o_hit       = w_hit;
  assign o_hit_idx   = w_hit_idx;
  assign o_hit_line  = r_line[w_hit_idx];
  assign o_head_addr = r_addr[i_head_idx];
  assign o_head_line = r_line[i_head_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      if (i_wr_en)  r_valid[i_wr_idx]  <= 1'b1;
      if (i_inv_en) r_valid[i_inv_idx] <= 1'b0;
    end
  end

  // Payload needs no reset: it is only ever observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_addr[i_wr_idx] <= i_wr_addr;
      r_line[i_wr_idx] <= i_wr_line;
    end
  end

endmodule

// File: rtl/line_write_buffer.sv
// Write-back line buffer between the cache memory port and main_mem; reads are served
// from buffered lines when they match, and buffered lines drain when the port is idle.
module line_write_buffer
  import cache_pkg::*;
#(
  parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
  parameter int ADDR_LEN      = DEF_ADDR_LEN,
  parameter int DEPTH         = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  line_write_buffer_if.slave   up,
  line_write_buffer_if.master  mem,
  output logic                 empty,
  output logic                 full
);

  localparam int LSZ   = line_size(LINE_ADDR_LEN);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [LSZ-1:0][31:0] wline_t;

  wb_state_e            r_state;
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;
  logic                 r_up_gnt;
  wline_t               r_up_rd_line;
  logic                 r_mem_rd_req;
  logic                 r_mem_wr_req;
  logic [ADDR_LEN-1:0]  r_mem_addr;
  wline_t               r_mem_wr_line;
  logic                 r_empty;
  logic                 r_full;

  logic                 w_hit;
  logic [PTR_W-1:0]     w_hit_idx;
  wline_t               w_hit_line;
  logic [ADDR_LEN-1:0]  w_head_addr;
  wline_t               w_head_line;
  logic                 w_idle_live;
  logic                 w_at_cap;
  logic                 w_wr_accept;
  logic                 w_enq;
  logic                 w_deq;
  logic [PTR_W-1:0]     w_wr_idx;
  logic [CNT_W-1:0]     w_count_nxt;

  wb_entry_array #(
    .ADDR_LEN (ADDR_LEN),
    .LSZ      (LSZ),
    .DEPTH    (DEPTH)
  ) u_entries (
    .clk           (clk),
    .rst           (rst),
    .i_lookup_addr (up.addr),
    .o_hit         (w_hit),
    .o_hit_idx     (w_hit_idx),
    .o_hit_line    (w_hit_line),
    .i_head_idx    (r_head),
    .o_head_addr   (w_head_addr),
    .o_head_line   (w_head_line),
    .i_wr_en       (w_wr_accept),
    .i_wr_idx      (w_wr_idx),
    .i_wr_addr     (up.addr),
    .i_wr_line     (up.wr_line),
    .i_inv_en      (w_deq),
    .i_inv_idx     (r_head)
  );

  // The IDLE cycle in which up_gnt is visible still sees the old req, so it is skipped.
  assign w_idle_live = (r_state == IDLE) && !r_up_gnt;
  assign w_at_cap    = (r_count == CNT_W'(DEPTH));
  assign w_wr_accept = w_idle_live && up.wr_req && (w_hit || !w_at_cap);
  assign w_enq       = w_wr_accept && !w_hit;
  assign w_deq       = (r_state == DRAIN) && mem.gnt;
  assign w_wr_idx    = w_hit ? w_hit_idx : r_tail;
  assign w_count_nxt = r_count + CNT_W'(w_enq) - CNT_W'(w_deq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_up_gnt      <= 1'b0;
      r_up_rd_line  <= '0;
      r_mem_rd_req  <= 1'b0;
      r_mem_wr_req  <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_line <= '0;
      r_empty       <= 1'b1;
      r_full        <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_empty  <= (w_count_nxt == '0);
      r_full   <= (w_count_nxt == CNT_W'(DEPTH));
      r_up_gnt <= 1'b0;
      if (w_enq) r_tail <= r_tail + 1'b1;
      if (w_deq) r_head <= r_head + 1'b1;

      case (r_state)
        IDLE: begin
          if (w_idle_live) begin
            if (up.wr_req) begin
              if (w_hit || !w_at_cap) begin
                r_state <= RESP;
              end else begin
                r_state       <= DRAIN;
                r_mem_wr_req  <= 1'b1;
                r_mem_addr    <= w_head_addr;
                r_mem_wr_line <= w_head_line;
              end
            end else if (up.rd_req) begin
              if (w_hit) begin
                r_up_rd_line <= w_hit_line;
                r_state      <= RESP;
              end else begin
                r_state      <= FILL;
                r_mem_rd_req <= 1'b1;
                r_mem_addr   <= up.addr;
              end
            end else if (r_count != '0) begin
              r_state       <= DRAIN;
              r_mem_wr_req  <= 1'b1;
              r_mem_addr    <= w_head_addr;
              r_mem_wr_line <= w_head_line;
            end
          end
        end
        FILL: begin
          if (mem.gnt) begin
            r_up_rd_line <= mem.rd_line;
            r_mem_rd_req <= 1'b0;
            r_mem_addr   <= '0;
            r_state      <= RESP;
          end
        end
        DRAIN: begin
          if (mem.gnt) begin
            r_mem_wr_req <= 1'b0;
            r_mem_addr   <= '0;
            r_state      <= IDLE;
          end
        end
        RESP: begin
          r_up_gnt <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign up.gnt      = r_up_gnt;
  assign up.rd_line  = r_up_rd_line;
  assign mem.addr    = r_mem_addr;
  assign mem.rd_req  = r_mem_rd_req;
  assign mem.wr_req  = r_mem_wr_req;
  assign mem.wr_line = r_mem_wr_line;
  assign empty       = r_empty;
  assign full        = r_full;

endmodule

// File: tb/tb_line_write_buffer.sv
// Directed bench for line_write_buffer: a main_mem model with a hold switch, hand-written
// corner-case sequences and a table of read/write vectors checked for coherent read data.
module tb_line_write_buffer;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic empty, full;

  always #5 clk = ~clk;

  line_write_buffer_if up_if ();
  line_write_buffer_if mem_if ();

  line_write_buffer #(
    .LINE_ADDR_LEN (DEF_LINE_ADDR_LEN),
    .ADDR_LEN      (DEF_ADDR_LEN),
    .DEPTH         (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .up    (up_if),
    .mem   (mem_if),
    .empty (empty),
    .full  (full)
  );

  int n_chk  = 0;
  int n_pass = 0;

  bit          mem_en  = 1'b0;
  int          mem_lat = 2;
  int          mon_first = 0;   // 0 none yet, 1 read, 2 write
  int          wr_log_n = 0;
  logic [8:0]  last_wr_addr;
  line_t       last_wr_line;
  line_t       mem_store [512];
  bit          mem_written [512];

  function automatic line_t make_line(input logic [15:0] seed);
    line_t l;
    for (int i = 0; i < LINE_SIZE; i++) l[i] = {seed, 16'(i)};
    return l;
  endfunction

  function automatic line_t mem_default(input logic [8:0] a);
    return make_line(16'hF000 | 16'(a));
  endfunction

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  // main_mem model: grants after mem_lat enabled cycles; holding mem_en low keeps it busy.
  initial begin
    int busy;
    busy = 0;
    mem_if.gnt = 1'b0;
    mem_if.rd_line = '0;
    for (int i = 0; i < 512; i++) mem_written[i] = 1'b0;
    forever begin
      @(negedge clk);
      mem_if.gnt = 1'b0;
      if (mem_if.rd_req || mem_if.wr_req) begin
        if (mon_first == 0) mon_first = mem_if.rd_req ? 1 : 2;
        if (mem_en) busy++;
        if (busy >= mem_lat) begin
          busy = 0;
          mem_if.gnt = 1'b1;
          if (mem_if.wr_req) begin
            mem_store[mem_if.addr]   = mem_if.wr_line;
            mem_written[mem_if.addr] = 1'b1;
            last_wr_addr = mem_if.addr;
            last_wr_line = mem_if.wr_line;
            wr_log_n++;
          end else begin
            mem_if.rd_line = mem_written[mem_if.addr] ? mem_store[mem_if.addr]
                                                      : mem_default(mem_if.addr);
          end
        end
      end else begin
        busy = 0;
      end
    end
  end

  task automatic start_req(input bit wr, input logic [8:0] a, input line_t l);
    up_if.addr    = a;
    up_if.wr_req  = wr;
    up_if.rd_req  = !wr;
    up_if.wr_line = l;
  endtask

  task automatic end_req();
    up_if.wr_req = 1'b0;
    up_if.rd_req = 1'b0;
  endtask

  task automatic wait_gnt(output int lat);
    lat = -1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (up_if.gnt) begin
        lat = n;
        break;
      end
    end
  endtask

  // sel: 0 mem_wr_req high, 1 mem_rd_req high, 2 empty high
  task automatic wait_cond(input int sel, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if ((sel == 0 && mem_if.wr_req) || (sel == 1 && mem_if.rd_req) || (sel == 2 && empty)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    bit          wr;
    logic [8:0]  addr;
    logic [15:0] seed;   // written seed, or expected seed for a read
  } vec_t;

  vec_t vecs [12];

  initial begin
    int lat;
    bit ok;
    int n0;

    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit ok;
    int n0;

    vecs[0]  = '{1'b1, 9'h100, 16'h0011};
    vecs[1]  = '{1'b0, 9'h100, 16'h0011};
    vecs[2]  = '{1'b1, 9'h100, 16'h0012};
    vecs[3]  = '{1'b0, 9'h100, 16'h0012};
    vecs[4]  = '{1'b0, 9'h012, 16'h000B};
    vecs[5]  = '{1'b0, 9'h0AA, 16'hF0AA};
    vecs[6]  = '{1'b1, 9'h0AA, 16'h0013};
    vecs[7]  = '{1'b0, 9'h0AA, 16'h0013};
    vecs[8]  = '{1'b0, 9'h001, 16'h0101};
    vecs[9]  = '{1'b0, 9'h005, 16'h0105};
    vecs[10] = '{1'b0, 9'h040, 16'h0040};
    vecs[11] = '{1'b0, 9'h033, 16'hF033};

    rst = 1'b1;
    up_if.addr = '0; up_if.wr_req = 1'b0; up_if.rd_req = 1'b0; up_if.wr_line = '0;
    repeat (3) @(negedge clk);
    check("rst_up_gnt", up_if.gnt, 0);
    check("rst_mem_rd_req", mem_if.rd_req, 0);
    check("rst_mem_wr_req", mem_if.wr_req, 0);
    check("rst_mem_addr", mem_if.addr, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single write: accept latency, then drain to memory.
    mem_en = 1'b0;
    start_req(1'b1, 9'h012, make_line(16'h0000));
    wait_gnt(lat);
    end_req();
    check("wr_accept_lat", lat, 2);
    check("wr1_empty", empty, 0);
    check("wr1_full", full, 0);
    wait_cond(0, ok);
    check("drain1_start", ok, 1);
    check("drain1_addr", mem_if.addr, 9'h012);
    check("drain1_line", mem_if.wr_line, make_line(16'h0000));
    n0 = wr_log_n;
    mem_en = 1'b1;
    wait_cond(2, ok);
    check("drain1_empty", ok, 1);
    check("drain1_writes", wr_log_n - n0, 1);
    check("drain1_mem_addr", last_wr_addr, 9'h012);
    check("drain1_idle_wr_req", mem_if.wr_req, 0);
    check("drain1_idle_addr", mem_if.addr, 0);

    // Coalesce: two back-to-back writes to one address leave a single entry.
    mem_en = 1'b0;
    start_req(1'b1, 9'h012, make_line(16'h000A));
    wait_gnt(lat);
    start_req(1'b1, 9'h012, make_line(16'h000B));
    wait_gnt(lat);
    end_req();
    check("coal_gnt", lat > 0, 1);
    wait_cond(0, ok);
    check("coal_drain_start", ok, 1);
    check("coal_drain_line", mem_if.wr_line, make_line(16'h000B));
    n0 = wr_log_n;
    mem_en = 1'b1;
    wait_cond(2, ok);
    check("coal_empty", ok, 1);
    repeat (20) @(negedge clk);
    check("coal_single_write", wr_log_n - n0, 1);

    // Read hit right behind a write, before any drain.
    mem_en = 1'b0;
    mon_first = 0;
    start_req(1'b1, 9'h040, make_line(16'h0040));
    wait_gnt(lat);
    start_req(1'b0, 9'h040, '0);
    wait_gnt(lat);
    end_req();
    check("rdhit_gnt", lat > 0, 1);
    check("rdhit_line", up_if.rd_line, make_line(16'h0040));
    check("rdhit_no_mem_yet", mon_first, 0);
    mem_en = 1'b1;
    wait_cond(2, ok);
    check("rdhit_drained", ok, 1);
    check("rdhit_first_mem_is_wr", mon_first, 2);

    // Fill to DEPTH, then a fifth distinct write forces a head drain first.
    mem_en = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      start_req(1'b1, 9'(k), make_line(16'h0100 + 16'(k)));
      wait_gnt(lat);
      check($sformatf("fill%0d_gnt", k), lat > 0, 1);
    end
    check("fill_full", full, 1);
    start_req(1'b1, 9'h005, make_line(16'h0105));
    wait_cond(0, ok);
    check("full_drain_start", ok, 1);
    check("full_drain_addr", mem_if.addr, 9'h001);
    check("full_drain_line", mem_if.wr_line, make_line(16'h0101));
    check("full_gnt_held", up_if.gnt, 0);
    n0 = wr_log_n;
    mem_en = 1'b1;
    wait_gnt(lat);
    end_req();
    check("full_accept_gnt", lat > 0, 1);
    check("full_after_accept", full, 1);
    check("full_one_drain", wr_log_n - n0, 1);
    wait_cond(2, ok);
    check("full_all_drained", ok, 1);
    check("full_drain_count", wr_log_n - n0, 5);
    check("full_last_drained", last_wr_addr, 9'h005);

    // Read miss with two lines buffered: the fill goes out before any drain.
    mem_en = 1'b0;
    mon_first = 0;
    n0 = wr_log_n;
    start_req(1'b1, 9'h021, make_line(16'h0021));
    wait_gnt(lat);
    start_req(1'b1, 9'h022, make_line(16'h0022));
    wait_gnt(lat);
    start_req(1'b0, 9'h1FF, '0);
    wait_cond(1, ok);
    check("miss_rd_req", ok, 1);
    check("miss_rd_first", mon_first, 1);
    check("miss_rd_addr", mem_if.addr, 9'h1FF);
    mem_en = 1'b1;
    wait_gnt(lat);
    end_req();
    check("miss_gnt", lat > 0, 1);
    check("miss_line", up_if.rd_line, make_line(16'hF1FF));
    check("miss_not_empty", empty, 0);
    wait_cond(2, ok);
    check("miss_drained", ok, 1);
    check("miss_drain_count", wr_log_n - n0, 2);

    // Reset in the middle of a drain drops the buffered line.
    mem_en = 1'b0;
    start_req(1'b1, 9'h033, make_line(16'h0033));
    wait_gnt(lat);
    end_req();
    wait_cond(0, ok);
    check("rstd_drain_start", ok, 1);
    #2 rst = 1'b1;
    #1;
    check("rstd_wr_req", mem_if.wr_req, 0);
    check("rstd_rd_req", mem_if.rd_req, 0);
    check("rstd_addr", mem_if.addr, 0);
    check("rstd_wr_line", mem_if.wr_line, 0);
    check("rstd_rd_line", up_if.rd_line, 0);
    check("rstd_up_gnt", up_if.gnt, 0);
    check("rstd_empty", empty, 1);
    check("rstd_full", full, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_first = 0;
    mem_en = 1'b1;
    start_req(1'b0, 9'h033, '0);
    wait_gnt(lat);
    end_req();
    check("rstd_read_gnt", lat > 0, 1);
    check("rstd_read_from_mem", mon_first, 1);
    check("rstd_read_line", up_if.rd_line, make_line(16'hF033));

    // Table of mixed traffic: every read must return the newest written value.
    mem_en = 1'b1;
    mem_lat = 2;
    for (int i = 0; i < 12; i++) begin
      start_req(vecs[i].wr, vecs[i].addr, vecs[i].wr ? make_line(vecs[i].seed) : '0);
      wait_gnt(lat);
      end_req();
      if (vecs[i].wr) check($sformatf("tbl%0d_wr_gnt", i), lat > 0, 1);
      else check($sformatf("tbl%0d_rd_line", i), up_if.rd_line, make_line(vecs[i].seed));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_cond(2, ok);
    check("tbl_final_empty", ok, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
